conv3x3_prog_kernel: RTL and testbench

- Parametrised successor of the fixed sharpening datapath: a 3x3 convolution over a pre-formed window with run-time programmable signed coefficients and a programmable normalising right shift.
- Output modes: clamp, absolute-value and bypass. Saturation events are reported and counted.
- Sits between the 3x3 window generator (line buffers) and the output pixel formatter.
- Fixed 4-cycle latency; done/valid travels alongside the data, no back-pressure.

---
 rtl/conv_pkg.sv | 68 ++++++
 rtl/conv_coef_bank.sv | 72 +++++++
 rtl/conv3x3_prog_kernel.sv | 199 +++++++++++++++++++
 tb/tb_conv3x3_prog_kernel.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : conv_pkg
// Brief    : Shared constants for the programmable 3x3 convolution kernel:
//            output mode encodings, coefficient address map, default sharpen
//            kernel and accumulator width derivations.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Output mode encodings; the reserved code behaves like plain clamp
    typedef enum logic [1:0] {
        MODE_CLAMP  = 2'b00,
        MODE_ABS    = 2'b01,
        MODE_BYPASS = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int NUM_TAPS = 9;
    localparam int ADDR_W   = 4;
    localparam int SHIFT_W  = 3;

    // Coefficient write address map
    localparam logic [ADDR_W-1:0] ADDR_K0    = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_K1    = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_K2    = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_K3    = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_K4    = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_K5    = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_K6    = 4'd6;
    localparam logic [ADDR_W-1:0] ADDR_K7    = 4'd7;
    localparam logic [ADDR_W-1:0] ADDR_K8    = 4'd8;
    localparam logic [ADDR_W-1:0] ADDR_SHIFT = 4'd9;

    // Sharpen kernel: corners 0, cross neighbours -1, centre 5
    localparam int DEF_K_CORNER = 0;
    localparam int DEF_K_EDGE   = -1;
    localparam int DEF_K_CENTRE = 5;
    localparam int DEF_SHIFT    = 0;

    // Default coefficient for tap idx (raster order, idx 4 is the centre)
    function automatic int default_coef(input int idx);
        if (idx == 4) begin
            return DEF_K_CENTRE;
        end else if ((idx % 2) == 1) begin
            return DEF_K_EDGE;
        end else begin
            return DEF_K_CORNER;
        end
    endfunction

    // Width of one pixel x coefficient product (pixel zero-extended by one bit)
    function automatic int prod_w(input int width, input int coef_w);
        return width + coef_w + 1;
    endfunction

    // Width of a three-product row sum
    function automatic int row_w(input int width, input int coef_w);
        return width + coef_w + 3;
    endfunction

    // Width of the nine-product accumulator
    function automatic int acc_w(input int width, input int coef_w);
        return width + coef_w + 5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_coef_bank.sv
`default_nettype none
// ============================================================================
// Module   : conv_coef_bank
// Brief    : Double-buffered coefficient store. Writes land in the shadow
//            bank; a commit copies the shadow bank (including a write on the
//            same edge) into the active bank that feeds the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module conv_coef_bank
    import conv_pkg::*;
#(
    parameter int COEF_W = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             coef_wr_en,
    input  logic [ADDR_W-1:0]                coef_wr_addr,
    input  logic [COEF_W-1:0]                coef_wr_data,
    input  logic                             coef_commit,
    output logic [NUM_TAPS-1:0][COEF_W-1:0]  active_coef,
    output logic [SHIFT_W-1:0]               active_shift
);

    logic [NUM_TAPS-1:0][COEF_W-1:0] shadow_q, shadow_d;
    logic [NUM_TAPS-1:0][COEF_W-1:0] active_q, active_d;
    logic [SHIFT_W-1:0]              shadow_shift_q, shadow_shift_d;
    logic [SHIFT_W-1:0]              active_shift_q, active_shift_d;

    // Shadow write decode and commit; commit sees this cycle's write
    always_comb begin
        shadow_d       = shadow_q;
        shadow_shift_d = shadow_shift_q;
        active_d       = active_q;
        active_shift_d = active_shift_q;
        if (coef_wr_en) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (coef_wr_addr == (ADDR_K0 + ADDR_W'(i))) begin
                    shadow_d[i] = coef_wr_data;
                end
            end
            if (coef_wr_addr == ADDR_SHIFT) begin
                shadow_shift_d = coef_wr_data[SHIFT_W-1:0];
            end
        end
        if (coef_commit) begin
            active_d       = shadow_d;
            active_shift_d = shadow_shift_d;
        end
    end

    // Bank registers; reset restores the sharpen kernel in both banks
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow_q[i] <= COEF_W'(default_coef(i));
                active_q[i] <= COEF_W'(default_coef(i));
            end
            shadow_shift_q <= SHIFT_W'(DEF_SHIFT);
            active_shift_q <= SHIFT_W'(DEF_SHIFT);
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            shadow_shift_q <= shadow_shift_d;
            active_shift_q <= active_shift_d;
        end
    end

    assign active_coef  = active_q;
    assign active_shift = active_shift_q;

endmodule
`default_nettype wire

// File: rtl/conv3x3_prog_kernel.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_prog_kernel
// Brief    : 3x3 convolution over a pre-formed window with programmable
//            signed coefficients, rounding right shift, clamp/abs/bypass
//            output modes and a saturating clamp-event counter.
//            Fixed 4-cycle latency, no back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_prog_kernel
    import conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int COEF_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in_0,
    input  logic [WIDTH-1:0]  data_in_1,
    input  logic [WIDTH-1:0]  data_in_2,
    input  logic [WIDTH-1:0]  data_in_3,
    input  logic [WIDTH-1:0]  data_in_4,
    input  logic [WIDTH-1:0]  data_in_5,
    input  logic [WIDTH-1:0]  data_in_6,
    input  logic [WIDTH-1:0]  data_in_7,
    input  logic [WIDTH-1:0]  data_in_8,
    input  logic              data_in_done,
    input  logic [1:0]        mode,
    input  logic              coef_wr_en,
    input  logic [3:0]        coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    input  logic              coef_commit,
    input  logic              sat_cnt_clr,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_out_done,
    output logic              sat_flag,
    output logic [CNT_W-1:0]  sat_count
);

    localparam int PROD_W = prod_w(WIDTH, COEF_W);
    localparam int ROW_W  = row_w(WIDTH, COEF_W);
    localparam int ACC_W  = acc_w(WIDTH, COEF_W);

    localparam logic signed [ACC_W-1:0] MAX_PIX_ACC = ACC_W'((1 << WIDTH) - 1);
    localparam logic [WIDTH-1:0]        MAX_PIX     = {WIDTH{1'b1}};

    // Window in raster order
    logic [WIDTH-1:0] pix [NUM_TAPS];
    assign pix[0] = data_in_0;
    assign pix[1] = data_in_1;
    assign pix[2] = data_in_2;
    assign pix[3] = data_in_3;
    assign pix[4] = data_in_4;
    assign pix[5] = data_in_5;
    assign pix[6] = data_in_6;
    assign pix[7] = data_in_7;
    assign pix[8] = data_in_8;

    logic [NUM_TAPS-1:0][COEF_W-1:0] active_coef;
    logic [SHIFT_W-1:0]              active_shift;

    conv_coef_bank #(
        .COEF_W (COEF_W)
    ) u_coef_bank (
        .clk          (clk),
        .reset        (reset),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .coef_commit  (coef_commit),
        .active_coef  (active_coef),
        .active_shift (active_shift)
    );

    // Pipeline state
    logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
    logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
    logic signed [ROW_W-1:0]  row_q [3];
    logic signed [ROW_W-1:0]  row_d [3];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  sum_w, rnd_w, abs_w;
    mode_e                    mode1_q, mode2_q, mode3_q;
    logic [WIDTH-1:0]         centre1_q, centre2_q, centre3_q;
    logic [SHIFT_W-1:0]       shift1_q, shift2_q;
    logic [WIDTH-1:0]         pix_val_w;
    logic                     clamp_w;

    logic [3:0]               vld_q, vld_d;
    logic [WIDTH-1:0]         data_out_q, data_out_d;
    logic                     sat_flag_q, sat_flag_d;
    logic [CNT_W-1:0]         sat_count_q, sat_count_d;

    // Stage 1: nine signed products using the bank as it stands this edge
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            prod_d[i] = PROD_W'(signed'({1'b0, pix[i]})) * PROD_W'(signed'(active_coef[i]));
        end
    end

    // Stage 2: three row sums
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_d[r] = ROW_W'(prod_q[3*r]) + ROW_W'(prod_q[3*r+1]) + ROW_W'(prod_q[3*r+2]);
        end
    end

    // Stage 3: total sum then round-half-up arithmetic right shift
    always_comb begin
        sum_w = ACC_W'(row_q[0]) + ACC_W'(row_q[1]) + ACC_W'(row_q[2]);
        rnd_w = '0;
        if (shift2_q != '0) begin
            rnd_w = ACC_W'(1) <<< (shift2_q - SHIFT_W'(1));
        end
        acc_d = (sum_w + rnd_w) >>> shift2_q;
    end

    // Stage 4: mode selection and clamping of the shifted sum
    always_comb begin
        pix_val_w = '0;
        clamp_w   = 1'b0;
        abs_w     = '0;
        case (mode3_q)
            MODE_BYPASS: begin
                pix_val_w = centre3_q;
            end
            MODE_ABS: begin
                abs_w = acc_q[ACC_W-1] ? -acc_q : acc_q;
                if (abs_w > MAX_PIX_ACC) begin
                    pix_val_w = MAX_PIX;
                    clamp_w   = 1'b1;
                end else begin
                    pix_val_w = abs_w[WIDTH-1:0];
                end
            end
            default: begin
                if (acc_q[ACC_W-1]) begin
                    pix_val_w = '0;
                    clamp_w   = 1'b1;
                end else if (acc_q > MAX_PIX_ACC) begin
                    pix_val_w = MAX_PIX;
                    clamp_w   = 1'b1;
                end else begin
                    pix_val_w = acc_q[WIDTH-1:0];
                end
            end
        endcase
    end

    // Valid shift, output capture gated by stage-3 valid, saturating counter
    always_comb begin
        vld_d       = {vld_q[2:0], data_in_done};
        data_out_d  = vld_q[2] ? pix_val_w : data_out_q;
        sat_flag_d  = vld_q[2] & clamp_w;
        sat_count_d = sat_count_q;
        if (sat_cnt_clr) begin
            sat_count_d = '0;
        end else if (sat_flag_d && (sat_count_q != {CNT_W{1'b1}})) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    // Datapath registers; validity is tracked separately so no reset needed
    always_ff @(posedge clk) begin
        prod_q    <= prod_d;
        mode1_q   <= mode_e'(mode);
        centre1_q <= data_in_4;
        shift1_q  <= active_shift;
        row_q     <= row_d;
        mode2_q   <= mode1_q;
        centre2_q <= centre1_q;
        shift2_q  <= shift1_q;
        acc_q     <= acc_d;
        mode3_q   <= mode2_q;
        centre3_q <= centre2_q;
    end

    // Control and output registers; reset drops in-flight windows
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            data_out_q  <= '0;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            vld_q       <= vld_d;
            data_out_q  <= data_out_d;
            sat_flag_q  <= sat_flag_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_out_done = vld_q[3];
    assign sat_flag      = sat_flag_q;
    assign sat_count     = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_prog_kernel.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_prog_kernel
// Brief    : Scoreboard bench for conv3x3_prog_kernel. The driver computes
//            each window's expected pixel/flag from a plain-integer model of
//            the kernel and queues it with its due cycle; a monitor pops and
//            compares, and tracks the saturation counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_prog_kernel;

    localparam int WIDTH  = 8;
    localparam int COEF_W = 4;
    localparam int CNT_W  = 16;
    localparam int MAXC   = (1 << CNT_W) - 1;

    typedef struct {
        int data;
        bit flag;
        int due;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [WIDTH-1:0]  px [9];
    logic              data_in_done = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              coef_wr_en = 1'b0;
    logic [3:0]        coef_wr_addr = 4'd0;
    logic [COEF_W-1:0] coef_wr_data = '0;
    logic              coef_commit = 1'b0;
    logic              sat_cnt_clr = 1'b0;
    logic [WIDTH-1:0]  data_out;
    logic              data_out_done;
    logic              sat_flag;
    logic [CNT_W-1:0]  sat_count;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    exp_t expq[$];

    int SHARPEN [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    int mdl_shadow [9];
    int mdl_active [9];
    int mdl_sh_shift = 0;
    int mdl_act_shift = 0;
    int mdl_count = 0;
    int last_out = 0;
    exp_t mon_e;
    bit mon_flag;

    always #5 clk = ~clk;

    conv3x3_prog_kernel #(
        .WIDTH  (WIDTH),
        .COEF_W (COEF_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in_0     (px[0]),
        .data_in_1     (px[1]),
        .data_in_2     (px[2]),
        .data_in_3     (px[3]),
        .data_in_4     (px[4]),
        .data_in_5     (px[5]),
        .data_in_6     (px[6]),
        .data_in_7     (px[7]),
        .data_in_8     (px[8]),
        .data_in_done  (data_in_done),
        .mode          (mode),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_addr  (coef_wr_addr),
        .coef_wr_data  (coef_wr_data),
        .coef_commit   (coef_commit),
        .sat_cnt_clr   (sat_cnt_clr),
        .data_out      (data_out),
        .data_out_done (data_out_done),
        .sat_flag      (sat_flag),
        .sat_count     (sat_count)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference: sum of products, rounding shift, then output mode rule
    function automatic exp_t model(input int md);
        exp_t e;
        int   sum;
        int   v;
        int   a;
        sum = 0;
        for (int i = 0; i < 9; i++) sum += mdl_active[i] * int'(px[i]);
        v = (mdl_act_shift > 0) ? ((sum + (1 << (mdl_act_shift - 1))) >>> mdl_act_shift) : sum;
        e.due = 0;
        if (md == 2) begin
            e.data = int'(px[4]);
            e.flag = 1'b0;
        end else if (md == 1) begin
            a = (v < 0) ? -v : v;
            e.data = (a > 255) ? 255 : a;
            e.flag = (a > 255);
        end else begin
            e.data = (v < 0) ? 0 : ((v > 255) ? 255 : v);
            e.flag = (v < 0) || (v > 255);
        end
        return e;
    endfunction

    task automatic model_defaults();
        for (int i = 0; i < 9; i++) begin
            mdl_shadow[i] = SHARPEN[i];
            mdl_active[i] = SHARPEN[i];
        end
        mdl_sh_shift  = 0;
        mdl_act_shift = 0;
    endtask

    // One input cycle: drive, queue expectation, advance the bank model
    task automatic issue(input bit vld, input int md, input bit wr, input int addr,
                         input int wd, input bit cm, input bit clr);
        exp_t e;
        data_in_done = vld;
        mode         = 2'(md);
        coef_wr_en   = wr;
        coef_wr_addr = 4'(addr);
        coef_wr_data = COEF_W'(wd);
        coef_commit  = cm;
        sat_cnt_clr  = clr;
        if (vld) begin
            e = model(md);
            e.due = cycle + 4;
            expq.push_back(e);
        end
        if (wr) begin
            if (addr <= 8) mdl_shadow[addr] = wd;
            else if (addr == 9) mdl_sh_shift = wd & 7;
        end
        if (cm) begin
            mdl_active    = mdl_shadow;
            mdl_act_shift = mdl_sh_shift;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) issue(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill(input int corner, input int edge_px, input int centre);
        for (int i = 0; i < 9; i++) px[i] = (i % 2 == 1) ? 8'(edge_px) : 8'(corner);
        px[4] = 8'(centre);
    endtask

    task automatic program_kernel(input int k, input int s);
        for (int i = 0; i < 9; i++) issue(0, 0, 1, i, k, 0, 0);
        issue(0, 0, 1, 9, s, 0, 0);
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        data_in_done = 1'b0;
        coef_wr_en   = 1'b0;
        coef_commit  = 1'b0;
        sat_cnt_clr  = 1'b0;
        expq.delete();
        model_defaults();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare just after each active edge
    always @(posedge clk) begin
        #1;
        cycle++;
        if (reset) begin
            chk("rst_done", data_out_done, 0);
            chk("rst_data", data_out, 0);
            chk("rst_flag", sat_flag, 0);
            chk("rst_count", sat_count, 0);
            mdl_count = 0;
            last_out  = 0;
        end else begin
            mon_flag = 1'b0;
            if (expq.size() > 0 && expq[0].due == cycle) begin
                mon_e = expq.pop_front();
                chk("out_done", data_out_done, 1);
                chk("out_data", data_out, mon_e.data);
                chk("out_flag", sat_flag, mon_e.flag);
                last_out = mon_e.data;
                mon_flag = mon_e.flag;
            end else begin
                chk("idle_done", data_out_done, 0);
                chk("idle_hold", data_out, last_out);
                chk("idle_flag", sat_flag, 0);
            end
            if (sat_cnt_clr) mdl_count = 0;
            else if (mon_flag && mdl_count < MAXC) mdl_count++;
            chk("sat_count", sat_count, mdl_count);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 9; i++) px[i] = '0;
        model_defaults();
        @(negedge clk);
        do_reset(2);

        // Default sharpen kernel, clamp mode
        fill(99, 20, 60);  issue(1, 0, 0, 0, 0, 0, 0);
        fill(50, 50, 100); issue(1, 0, 0, 0, 0, 0, 0);
        fill(40, 40, 10);  issue(1, 0, 0, 0, 0, 0, 0);
        issue(1, 1, 0, 0, 0, 0, 0);
        idle(6);

        // Box blur staged in shadow: old kernel until commit
        program_kernel(1, 3);
        fill(80, 80, 80); issue(1, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 1, 0);
        issue(1, 0, 0, 0, 0, 0, 0);
        idle(6);

        // Commit during a back-to-back burst
        program_kernel(-1, 1);
        issue(0, 0, 1, 4, 7, 0, 0);
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 9; i++) px[i] = 8'($urandom_range(0, 255));
            issue(1, 0, 0, 0, 0, (w == 2), 0);
        end
        idle(6);

        // Reset with programmed kernel and windows in flight
        program_kernel(1, 3);
        issue(0, 0, 0, 0, 0, 1, 0);
        fill(200, 200, 200);
        repeat (3) issue(1, 0, 0, 0, 0, 0, 0);
        do_reset(1);
        idle(6);
        fill(80, 80, 80); issue(1, 0, 0, 0, 0, 0, 0);
        idle(6);

        // Bypass mode
        fill(255, 3, 8'h5A); issue(1, 2, 0, 0, 0, 0, 0);
        idle(6);

        // Three saturating windows, clear coincides with the third flag
        fill(0, 0, 255);
        repeat (3) issue(1, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 1);
        idle(6);

        // Randomised traffic with writes, commits, clears and gaps
        for (int n = 0; n < 400; n++) begin
            int addr;
            int wd;
            for (int i = 0; i < 9; i++) begin
                px[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1) * 255)
                                                    : 8'($urandom_range(0, 255));
            end
            addr = $urandom_range(0, 15);
            wd   = (addr == 9) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15)) - 8;
            issue(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), addr, wd,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0));
        end
        idle(8);

        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
